// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard event path: set-2 scancode
// constants, decoder state encoding, decoded event record and byte
// classification helpers.
package kb_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_OVR0     = 8'h00;
    localparam logic [7:0] SC_OVR1     = 8'hFF;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } kb_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } kb_event_t;

    // Keyboard status replies: silently discarded.
    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT_OK) || (b == SC_ECHO);
    endfunction

    // Keyboard-side fault/overrun codes: discarded and escalated.
    function automatic logic is_fault(input logic [7:0] b);
        return (b == SC_OVR0) || (b == SC_OVR1) || (b == SC_BAT_FAIL);
    endfunction

endpackage

// File: rtl/ps2_event_decoder_if.sv
// Signal bundle between the PS/2 byte receiver / host consumer (master)
// and the scancode event decoder (slave).
interface ps2_event_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic       overflow;
    logic       reset_request;

    modport master (
        output rx_data, rx_valid, rx_error, evt_ready,
        input  evt_code, evt_ext, evt_break, evt_valid, overflow, reset_request
    );

    modport slave (
        input  rx_data, rx_valid, rx_error, evt_ready,
        output evt_code, evt_ext, evt_break, evt_valid, overflow, reset_request
    );

endinterface

// File: rtl/kb_event_fifo.sv
// Show-ahead FIFO of decoded key events. DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  kb_event_t din,
    input  logic      pop,
    output kb_event_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    kb_event_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_event_decoder.sv
// PS/2 set-2 scancode event decoder. Folds E0/F0 prefixes into single
// {code, ext, brk} events, abandons stale prefixes after TIMEOUT_CYCLES,
// and requests a keyboard reset on receiver errors and fault codes.
// Optional build macro: KB_EVENT_FIFO_EN selects a FIFO_DEPTH-entry event
// FIFO; without it a single output register buffers one event.
module ps2_event_decoder
    import kb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input logic                 clk,
    input logic                 rst,
    ps2_event_decoder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    kb_state_e          state;
    kb_state_e          nxt_state;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               emit;
    kb_event_t          emit_evt;
    logic               req;
    logic               pop;
    logic               buf_full;
    kb_event_t          head;
    logic               head_valid;
    logic               reset_request_q;
    logic               overflow_q;

    assign pop = head_valid && bus.evt_ready;

    // Byte decode: next state, event to emit and reset-request trigger.
    always_comb begin
        nxt_state = state;
        emit      = 1'b0;
        emit_evt  = '{code: bus.rx_data, ext: 1'b0, brk: 1'b0};
        req       = 1'b0;
        if (bus.rx_error) begin
            nxt_state = ST_IDLE;
            req       = 1'b1;
        end else if (bus.rx_valid) begin
            if (is_status(bus.rx_data)) begin
                nxt_state = ST_IDLE;
            end else if (is_fault(bus.rx_data)) begin
                nxt_state = ST_IDLE;
                req       = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.rx_data == SC_EXT) begin
                            nxt_state = ST_EXT;
                        end else if (bus.rx_data == SC_BREAK) begin
                            nxt_state = ST_BRK;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (bus.rx_data == SC_BREAK) begin
                            nxt_state = ST_EXT_BRK;
                        end else if (bus.rx_data != SC_EXT) begin
                            emit         = 1'b1;
                            emit_evt.ext = 1'b1;
                            nxt_state    = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (bus.rx_data != SC_EXT && bus.rx_data != SC_BREAK) begin
                            emit         = 1'b1;
                            emit_evt.brk = 1'b1;
                            nxt_state    = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (bus.rx_data != SC_EXT && bus.rx_data != SC_BREAK) begin
                            emit         = 1'b1;
                            emit_evt.ext = 1'b1;
                            emit_evt.brk = 1'b1;
                            nxt_state    = ST_IDLE;
                        end
                    end
                    default: nxt_state = ST_IDLE;
                endcase
            end
        end else if (state != ST_IDLE && tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            nxt_state = ST_IDLE;
        end
    end

    // Decoder state, prefix timeout counter and registered reset request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            tmo_cnt         <= '0;
            reset_request_q <= 1'b0;
        end else begin
            state           <= nxt_state;
            reset_request_q <= req;
            if (bus.rx_valid || bus.rx_error || state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky drop flag: push into a full buffer with no pop that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (emit && buf_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef KB_EVENT_FIFO_EN
    kb_event_t  fifo_dout;
    logic       fifo_empty;

    kb_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emit),
        .din   (emit_evt),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (buf_full),
        .empty (fifo_empty)
    );

    // Unwritten entries must not leak onto evt_code while empty.
    assign head_valid = !fifo_empty;
    assign head       = fifo_empty ? '0 : fifo_dout;
`else
    kb_event_t  head_q;
    logic       head_valid_q;
    logic       unused_depth;

    assign unused_depth = ^FIFO_DEPTH;
    assign buf_full     = head_valid_q;
    assign head_valid   = head_valid_q;
    assign head         = head_q;

    // Single-entry buffer: reload on push when empty or being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else if (emit && (!head_valid_q || pop)) begin
            head_q       <= emit_evt;
            head_valid_q <= 1'b1;
        end else if (pop) begin
            head_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.evt_code      = head.code;
    assign bus.evt_ext       = head.ext;
    assign bus.evt_break     = head.brk;
    assign bus.evt_valid     = head_valid;
    assign bus.overflow      = overflow_q;
    assign bus.reset_request = reset_request_q;

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Scoreboard bench for ps2_event_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares on each handshake.
module tb_ps2_event_decoder;
    import kb_pkg::*;

    localparam int unsigned DEPTH_P = 8;
    localparam int unsigned TMO     = 40;
`ifdef KB_EVENT_FIFO_EN
    localparam int unsigned BUF_DEPTH = DEPTH_P;
`else
    localparam int unsigned BUF_DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_event_decoder_if bus ();

    ps2_event_decoder #(
        .FIFO_DEPTH     (DEPTH_P),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        tests    = 0;
    int        fails    = 0;
    int        rr_count = 0;
    kb_event_t exp_q[$];
    logic      hold_prev = 1'b0;
    kb_event_t hold_evt;

    function automatic kb_event_t mk(input logic [7:0] c, input logic e, input logic b);
        kb_event_t r;
        r.code = c;
        r.ext  = e;
        r.brk  = b;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: handshake scoreboard, head stability, reset_request cycles.
    always @(negedge clk) begin
        kb_event_t cur;
        kb_event_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            cur = {bus.evt_code, bus.evt_ext, bus.evt_break};
            if (bus.reset_request) rr_count++;
            if (hold_prev) begin
                tests++;
                if (!bus.evt_valid || cur !== hold_evt) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%0b %h, expected v=1 %h",
                             bus.evt_valid, cur, hold_evt);
                end
            end
            if (bus.evt_valid && bus.evt_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %h, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL event: got code=%h ext=%0b brk=%0b, expected code=%h ext=%0b brk=%0b",
                                 cur.code, cur.ext, cur.brk, e.code, e.ext, e.brk);
                    end
                end
            end
            hold_prev = bus.evt_valid && !bus.evt_ready;
            hold_evt  = cur;
        end
    end

    initial begin
        int rr_base;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.rx_error  = 1'b0;
        bus.evt_ready = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_evt_valid", bus.evt_valid, 0);
        check("rst_evt_code", bus.evt_code, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_reset_request", bus.reset_request, 0);

        // Single make code, one-cycle latency, popped
        exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
        send(8'h1C);
        check("latency_valid", bus.evt_valid, 1);
        check("latency_code", bus.evt_code, 'h1C);
        tick(1);
        check("after_pop_valid", bus.evt_valid, 0);

        // Break and extended-break sequences
        exp_q.push_back(mk(8'h1C, 1'b0, 1'b1));
        send(8'hF0); send(8'h1C);
        exp_q.push_back(mk(8'h74, 1'b1, 1'b1));
        send(8'hE0); send(8'hF0); send(8'h74);
        // Repeated prefixes, E1 as plain code, status byte aborting a prefix
        exp_q.push_back(mk(8'h75, 1'b1, 1'b0));
        send(8'hE0); send(8'hE0); send(8'h75);
        exp_q.push_back(mk(8'h12, 1'b0, 1'b1));
        send(8'hF0); send(8'hE0); send(8'hF0); send(8'h12);
        exp_q.push_back(mk(8'h11, 1'b1, 1'b1));
        send(8'hE0); send(8'hF0); send(8'hE0); send(8'h11);
        exp_q.push_back(mk(8'hE1, 1'b0, 1'b0));
        send(8'hE1);
        rr_base = rr_count;
        send(8'hE0); send(8'hFA);
        exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
        send(8'h1C);
        wait_drain("drain_prefix");
        check("status_no_request", rr_count - rr_base, 0);

        // Prefix timeout: just inside keeps it, just past discards it
        send(8'hE0);
        tick(TMO - 1);
        exp_q.push_back(mk(8'h1C, 1'b1, 1'b0));
        send(8'h1C);
        send(8'hE0);
        tick(TMO + 1);
        exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
        send(8'h1C);
        send(8'hF0);
        tick(TMO + 1);
        exp_q.push_back(mk(8'h2A, 1'b0, 1'b0));
        send(8'h2A);
        wait_drain("drain_timeout");
        check("timeout_no_request", rr_count - rr_base, 0);

        // Status drop, fault code pulse, receiver error during prefix
        send(8'hFA);
        check("fa_no_request", bus.reset_request, 0);
        send(8'hFF);
        check("ff_request", bus.reset_request, 1);
        tick(1);
        check("ff_request_end", bus.reset_request, 0);
        send(8'hF0);
        bus.rx_error = 1'b1;
        tick(1);
        bus.rx_error = 1'b0;
        check("err_request", bus.reset_request, 1);
        exp_q.push_back(mk(8'h1C, 1'b0, 1'b0));
        send(8'h1C);
        check("err_request_end", bus.reset_request, 0);
        send(8'hE0);
        bus.rx_error = 1'b1;
        send(8'h1C);
        bus.rx_error = 1'b0;
        check("err_wins_request", bus.reset_request, 1);
        exp_q.push_back(mk(8'h1B, 1'b0, 1'b0));
        send(8'h1B);
        send(8'hE0); send(8'hFC);
        check("fc_request", bus.reset_request, 1);
        exp_q.push_back(mk(8'h1D, 1'b0, 1'b0));
        send(8'h1D);
        wait_drain("drain_faults");
        check("request_cycles", rr_count - rr_base, 4);

        // Full buffer with simultaneous push and pop
        bus.evt_ready = 1'b0;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            exp_q.push_back(mk(8'h20 + 8'(i), 1'b0, 1'b0));
            send(8'h20 + 8'(i));
        end
        check("full_no_overflow", bus.overflow, 0);
        exp_q.push_back(mk(8'h30, 1'b0, 1'b0));
        bus.evt_ready = 1'b1;
        send(8'h30);
        check("push_pop_overflow", bus.overflow, 0);
        wait_drain("drain_push_pop");
        check("push_pop_overflow_end", bus.overflow, 0);

        // Overflow: one event past capacity is lost
        reset_dut();
        check("rst2_overflow", bus.overflow, 0);
        bus.evt_ready = 1'b0;
        for (int unsigned i = 0; i <= BUF_DEPTH; i++) begin
            if (i < BUF_DEPTH) exp_q.push_back(mk(8'(i + 1), 1'b0, 1'b0));
            send(8'(i + 1));
            if (i == BUF_DEPTH - 1) check("pre_drop_overflow", bus.overflow, 0);
        end
        check("drop_overflow", bus.overflow, 1);
        bus.evt_ready = 1'b1;
        wait_drain("drain_overflow");
        check("overflow_sticky", bus.overflow, 1);
        check("overflow_empty", bus.evt_valid, 0);
        reset_dut();
        check("overflow_cleared", bus.overflow, 0);

        tick(2);
        check("queue_empty_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
